// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, FSM state type and instruction field positions shared
// by the control unit and its decoder.
package cu_pkg;

    localparam int INSTR_WIDTH = 16;

    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0101;
    localparam logic [3:0] OP_JMP   = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int DEST_MSB   = 11;
    localparam int DEST_LSB   = 9;
    localparam int OPA_MSB    = 8;
    localparam int OPA_LSB    = 6;
    localparam int OPB_MSB    = 5;
    localparam int OPB_LSB    = 3;
    localparam int ADDR_MSB   = 7;
    localparam int ADDR_LSB   = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALTED
    } state_t;

endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: purely combinational split of the instruction register into
// opcode, register addresses, data-memory address and jump information.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic [INSTR_WIDTH-1:0] ir,
    output logic [3:0]             opcode,
    output logic [2:0]             op_a,
    output logic [2:0]             op_b,
    output logic [2:0]             dest,
    output logic [7:0]             mem_addr,
    output logic [PC_WIDTH-1:0]    jump_target,
    output logic                   is_jmp,
    output logic                   is_halt
);

    // Map each opcode class to the fields it actually uses; unused fields read 0
    always_comb begin
        opcode      = ir[OPCODE_MSB:OPCODE_LSB];
        op_a        = '0;
        op_b        = '0;
        dest        = '0;
        mem_addr    = '0;
        jump_target = '0;
        is_jmp      = 1'b0;
        is_halt     = 1'b0;
        case (ir[OPCODE_MSB:OPCODE_LSB])
            OP_LOAD: begin
                dest     = ir[DEST_MSB:DEST_LSB];
                mem_addr = ir[ADDR_MSB:ADDR_LSB];
            end
            OP_STORE: begin
                op_a     = ir[DEST_MSB:DEST_LSB];
                mem_addr = ir[ADDR_MSB:ADDR_LSB];
            end
            OP_JMP: begin
                is_jmp      = 1'b1;
                jump_target = ir[PC_WIDTH-1:0];
            end
            OP_HALT: begin
                is_halt = 1'b1;
            end
            default: begin
                dest = ir[DEST_MSB:DEST_LSB];
                op_a = ir[OPA_MSB:OPA_LSB];
                op_b = ir[OPB_MSB:OPB_LSB];
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: five-cycle, non-overlapped instruction sequencer. Fetches a
// word, latches it into ir, presents decoded fields to the execution unit and
// emits a one-cycle commit strobe in the write-back cycle.
module control_unit
    import cu_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [PC_WIDTH-1:0]    instr_addr,
    output logic                   instr_rd_en,
    input  logic [INSTR_WIDTH-1:0] instr_data,
    output logic [3:0]             opcode,
    output logic [2:0]             opAAdr,
    output logic [2:0]             opBAder,
    output logic [2:0]             dest_reg,
    output logic [7:0]             data_mem_addr,
    output logic                   commit,
    output logic                   halted,
    output logic [PC_WIDTH-1:0]    pc_out
);

    state_t                 state;
    state_t                 next_state;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_next;
    logic [INSTR_WIDTH-1:0] ir;
    logic [INSTR_WIDTH-1:0] ir_next;
    logic [PC_WIDTH-1:0]    jump_target;
    logic                   is_jmp;
    logic                   is_halt;

    cu_decoder #(
        .PC_WIDTH(PC_WIDTH)
    ) u_decoder (
        .ir         (ir),
        .opcode     (opcode),
        .op_a       (opAAdr),
        .op_b       (opBAder),
        .dest       (dest_reg),
        .mem_addr   (data_mem_addr),
        .jump_target(jump_target),
        .is_jmp     (is_jmp),
        .is_halt    (is_halt)
    );

    assign instr_addr = pc;
    assign pc_out     = pc;

    // State, program counter and instruction register; reset abandons any instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= next_state;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    // Sequencing, pc update and strobes; commit is masked while reset is high
    always_comb begin
        next_state  = state;
        pc_next     = pc;
        ir_next     = ir;
        instr_rd_en = 1'b0;
        commit      = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FETCH;
                    pc_next    = '0;
                end
            end
            FETCH: begin
                instr_rd_en = 1'b1;
                next_state  = DECODE;
            end
            DECODE: begin
                ir_next    = instr_data;
                next_state = EXEC;
            end
            EXEC: begin
                next_state = MEM;
            end
            MEM: begin
                next_state = WB;
            end
            WB: begin
                if (is_halt) begin
                    next_state = HALTED;
                end else if (is_jmp) begin
                    pc_next    = jump_target;
                    next_state = FETCH;
                end else begin
                    commit     = ~reset;
                    pc_next    = pc + PC_WIDTH'(1);
                    next_state = FETCH;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized and directed checks of control_unit against a
// program-level reference model (instruction table decode + pc arithmetic).
module tb_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [7:0]  instr_addr;
    logic        instr_rd_en;
    logic [15:0] instr_data;
    logic [3:0]  opcode;
    logic [2:0]  opAAdr;
    logic [2:0]  opBAder;
    logic [2:0]  dest_reg;
    logic [7:0]  data_mem_addr;
    logic        commit;
    logic        halted;
    logic [7:0]  pc_out;
    logic [20:0] fields;

    logic        reset2;
    logic        start2;
    logic [1:0]  instr_addr2;
    logic        instr_rd_en2;
    logic [15:0] instr_data2;
    logic [3:0]  opcode2;
    logic [2:0]  opAAdr2;
    logic [2:0]  opBAder2;
    logic [2:0]  dest_reg2;
    logic [7:0]  data_mem_addr2;
    logic        commit2;
    logic        halted2;
    logic [1:0]  pc_out2;

    logic [15:0] imem  [0:255];
    logic [15:0] imem2 [0:3];
    logic [15:0] prev_word;

    int checks = 0;
    int errors = 0;

    assign fields = {opcode, opAAdr, opBAder, dest_reg, data_mem_addr};

    control_unit #(.PC_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .instr_addr(instr_addr), .instr_rd_en(instr_rd_en), .instr_data(instr_data),
        .opcode(opcode), .opAAdr(opAAdr), .opBAder(opBAder), .dest_reg(dest_reg),
        .data_mem_addr(data_mem_addr), .commit(commit), .halted(halted), .pc_out(pc_out)
    );

    control_unit #(.PC_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset2), .start(start2),
        .instr_addr(instr_addr2), .instr_rd_en(instr_rd_en2), .instr_data(instr_data2),
        .opcode(opcode2), .opAAdr(opAAdr2), .opBAder(opBAder2), .dest_reg(dest_reg2),
        .data_mem_addr(data_mem_addr2), .commit(commit2), .halted(halted2), .pc_out(pc_out2)
    );

    // Instruction memories with one-cycle synchronous read
    always @(posedge clk) begin
        if (instr_rd_en) instr_data <= imem[instr_addr];
        if (instr_rd_en2) instr_data2 <= imem2[instr_addr2];
    end

    function automatic logic [20:0] model_fields(input logic [15:0] w);
        logic [3:0] op;
        logic [2:0] a, b, d;
        logic [7:0] m;
        op = w[15:12]; a = 3'd0; b = 3'd0; d = 3'd0; m = 8'd0;
        if (op == 4'h4) begin
            d = w[11:9]; m = w[7:0];
        end else if (op == 4'h5) begin
            a = w[11:9]; m = w[7:0];
        end else if (op != 4'hE && op != 4'hF) begin
            d = w[11:9]; a = w[8:6]; b = w[5:3];
        end
        return {op, a, b, d, m};
    endfunction

    function automatic logic model_commit(input logic [15:0] w);
        return (w[15:12] != 4'hE) && (w[15:12] != 4'hF);
    endfunction

    function automatic logic [7:0] model_next_pc(input logic [7:0] pc, input logic [15:0] w);
        int nxt;
        if (w[15:12] == 4'hE) nxt = int'(w[7:0]);
        else if (w[15:12] == 4'hF) nxt = int'(pc);
        else nxt = (int'(pc) + 1) % 256;
        return 8'(nxt);
    endfunction

    function automatic logic [15:0] rand_alu();
        logic [3:0] op;
        op = 4'($urandom_range(0, 11));
        if (op >= 4'd4) op = op + 4'd2;
        return {op, 12'($urandom)};
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        prev_word = 16'h0000;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_fetch(input string name);
        int n;
        n = 0;
        while (instr_rd_en !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_rd_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_fetch: rd_en=%b want 1", name, instr_rd_en);
        end
    endtask

    // One instruction from its FETCH cycle to the cycle after write-back
    task automatic exec_one(input logic [7:0] pc, output logic [7:0] npc, output bit halt_seen);
        logic [15:0] w;
        w = imem[pc];
        checks++;
        if (instr_addr !== pc) begin
            errors++; $display("[TB] FAIL fetch_addr: got %h want %h", instr_addr, pc);
        end
        checks++;
        if (pc_out !== pc) begin
            errors++; $display("[TB] FAIL pc_out: got %h want %h", pc_out, pc);
        end
        @(negedge clk);
        start = 1'($urandom);
        checks++;
        if ({instr_rd_en, commit} !== 2'b00) begin
            errors++; $display("[TB] FAIL decode_strobes: got %b want 00", {instr_rd_en, commit});
        end
        checks++;
        if (fields !== model_fields(prev_word)) begin
            errors++; $display("[TB] FAIL decode_hold: got %h want %h", fields, model_fields(prev_word));
        end
        @(negedge clk);
        start = 1'($urandom);
        checks++;
        if (fields !== model_fields(w) || commit !== 1'b0) begin
            errors++; $display("[TB] FAIL exec_fields: got %h/%b want %h/0", fields, commit, model_fields(w));
        end
        @(negedge clk);
        start = 1'($urandom);
        checks++;
        if (fields !== model_fields(w) || commit !== 1'b0) begin
            errors++; $display("[TB] FAIL mem_fields: got %h/%b want %h/0", fields, commit, model_fields(w));
        end
        @(negedge clk);
        start = 1'($urandom);
        checks++;
        if (commit !== model_commit(w)) begin
            errors++; $display("[TB] FAIL wb_commit: word %h got %b want %b", w, commit, model_commit(w));
        end
        npc = model_next_pc(pc, w);
        halt_seen = (w[15:12] == 4'hF);
        prev_word = w;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (halt_seen) begin
            if ({halted, instr_rd_en} !== 2'b10) begin
                errors++; $display("[TB] FAIL halt_entry: got %b want 10", {halted, instr_rd_en});
            end
        end else if (instr_rd_en !== 1'b1 || instr_addr !== npc) begin
            errors++; $display("[TB] FAIL next_fetch: got %b/%h want 1/%h", instr_rd_en, instr_addr, npc);
        end
    endtask

    task automatic run_program(input string name, input int max_instr,
                               output logic [7:0] last_pc, output bit did_halt, output int count);
        logic [7:0] pc;
        logic [7:0] npc;
        bit h;
        pc = 8'd0; did_halt = 1'b0; count = 0;
        for (int k = 0; k < max_instr; k++) begin
            wait_fetch(name);
            exec_one(pc, npc, h);
            count++;
            pc = npc;
            if (h) begin
                did_halt = 1'b1;
                break;
            end
        end
        last_pc = pc;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({instr_addr, instr_rd_en, fields, commit, halted, pc_out} !== 40'd0) begin
            errors++; $display("[TB] FAIL reset_values: got %h want 0",
                {instr_addr, instr_rd_en, fields, commit, halted, pc_out});
        end
        reset = 1'b0;
        start = 1'b0;
        prev_word = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({instr_rd_en, commit} !== 2'b00) begin
                errors++; $display("[TB] FAIL idle_hold: got %b want 00", {instr_rd_en, commit});
            end
        end
    endtask

    task automatic test_program();
        logic [7:0] last_pc;
        bit did_halt;
        int count;
        fill_halt();
        imem[0] = 16'h0A50; imem[1] = 16'h4612; imem[2] = 16'hE005;
        imem[5] = 16'h5A34; imem[6] = 16'hE003; imem[3] = 16'hF000;
        do_reset();
        start_pulse();
        run_program("prog", 10, last_pc, did_halt, count);
        checks++;
        if (!did_halt || last_pc !== 8'd3 || count != 6) begin
            errors++; $display("[TB] FAIL prog_path: halt=%0d pc=%h n=%0d want 1/03/6", did_halt, last_pc, count);
        end
        repeat (6) begin
            @(negedge clk);
            start = 1'($urandom);
            checks++;
            if ({halted, instr_rd_en, commit, pc_out} !== {3'b100, 8'd3}) begin
                errors++; $display("[TB] FAIL halted_hold: got %h want %h",
                    {halted, instr_rd_en, commit, pc_out}, {3'b100, 8'd3});
            end
        end
        start = 1'b0;
        do_reset();
        checks++;
        if ({halted, pc_out} !== 9'd0) begin
            errors++; $display("[TB] FAIL halt_clear: got %h want 0", {halted, pc_out});
        end
    endtask

    task automatic test_jmp_self();
        logic [7:0] last_pc;
        bit did_halt;
        int count;
        fill_halt();
        imem[0] = rand_alu();
        imem[1] = 16'hE001;
        do_reset();
        start_pulse();
        run_program("self", 5, last_pc, did_halt, count);
        checks++;
        if (did_halt || halted !== 1'b0 || pc_out !== 8'd1) begin
            errors++; $display("[TB] FAIL self_loop: halt=%b pc=%h want 0/01", halted, pc_out);
        end
    endtask

    task automatic test_wrap8();
        logic [7:0] last_pc;
        bit did_halt;
        int count;
        fill_halt();
        imem[0] = 16'hE0FF;
        imem[255] = rand_alu();
        do_reset();
        start_pulse();
        run_program("wrap8", 4, last_pc, did_halt, count);
        checks++;
        if (did_halt || pc_out !== 8'd0) begin
            errors++; $display("[TB] FAIL wrap8_pc: got %h want 00", pc_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] last_pc;
        bit did_halt;
        int count;
        int r;
        int t;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
            for (int i = 0; i < 23; i++) begin
                r = $urandom_range(0, 9);
                if (r <= 5) imem[i] = rand_alu();
                else if (r <= 7) imem[i] = {4'h4, 12'($urandom)};
                else if (r == 8) imem[i] = {4'h5, 12'($urandom)};
                else begin
                    t = i + 1 + $urandom_range(0, 3);
                    if (t > 23) t = 23;
                    imem[i] = {4'hE, 4'($urandom), 8'(t)};
                end
            end
            imem[23] = {4'hF, 12'($urandom)};
            do_reset();
            start_pulse();
            run_program("rand", 40, last_pc, did_halt, count);
            checks++;
            if (!did_halt || last_pc !== 8'd23) begin
                errors++; $display("[TB] FAIL rand_halt: halt=%0d pc=%h want 1/17", did_halt, last_pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_halt();
        imem[0] = 16'h0A50;
        do_reset();
        start_pulse();
        wait_fetch("rstmem");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        checks++;
        if (commit !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mem_commit: got %b want 0", commit);
        end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({instr_rd_en, pc_out, fields, halted, commit} !== 32'd0) begin
            errors++; $display("[TB] FAIL rst_mem_idle: got %h want 0", {instr_rd_en, pc_out, fields, halted, commit});
        end
        repeat (6) begin
            @(negedge clk);
            checks++;
            if ({commit, instr_rd_en} !== 2'b00) begin
                errors++; $display("[TB] FAIL rst_mem_quiet: got %b want 00", {commit, instr_rd_en});
            end
        end
        prev_word = 16'h0000;
        start_pulse();
        wait_fetch("rstwb");
        repeat (4) @(negedge clk);
        checks++;
        if (commit !== 1'b1) begin
            errors++; $display("[TB] FAIL wb_commit_pre: got %b want 1", commit);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (commit !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_wb_commit: got %b want 0", commit);
        end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({pc_out, instr_rd_en} !== 9'd0) begin
            errors++; $display("[TB] FAIL rst_wb_pc: got %h want 0", {pc_out, instr_rd_en});
        end
    endtask

    task automatic test_pc_width2();
        int commits;
        int n;
        for (int i = 0; i < 4; i++) imem2[i] = rand_alu();
        @(negedge clk);
        reset2 = 1'b1;
        @(negedge clk);
        reset2 = 1'b0;
        checks++;
        if ({instr_addr2, instr_rd_en2, opcode2, opAAdr2, opBAder2, dest_reg2,
             data_mem_addr2, commit2, halted2, pc_out2} !== 29'd0) begin
            errors++; $display("[TB] FAIL w2_reset: got %h want 0",
                {instr_addr2, instr_rd_en2, opcode2, opAAdr2, opBAder2, dest_reg2,
                 data_mem_addr2, commit2, halted2, pc_out2});
        end
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        commits = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (instr_rd_en2 !== 1'b1 && n < 10) begin
                @(negedge clk);
                if (commit2 === 1'b1) commits++;
                n++;
            end
            checks++;
            if (instr_rd_en2 !== 1'b1 || instr_addr2 !== 2'(k % 4)) begin
                errors++; $display("[TB] FAIL w2_addr: got %b/%0d want 1/%0d", instr_rd_en2, instr_addr2, k % 4);
            end
            if (k > 0) begin
                checks++;
                if (commits != 1) begin
                    errors++; $display("[TB] FAIL w2_commits: got %0d want 1", commits);
                end
            end
            commits = 0;
            @(negedge clk);
        end
        reset2 = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        reset2 = 1'b1;
        start2 = 1'b0;
        prev_word = 16'h0000;
        fill_halt();
        for (int i = 0; i < 4; i++) imem2[i] = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        $display("[TB] starting control_unit bench");
        test_reset();
        test_program();
        test_jmp_self();
        test_wrap8();
        test_random();
        test_reset_mid();
        test_pc_width2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer driving the execution unit. Fetches 16-bit instructions from instruction memory and decodes them into opcode, operand-address and destination-register fields. Drives the data-memory address for loads and stores. Emits a one-cycle `commit` strobe that qualifies register-memory and data-memory writes. Acts as the initiator for the execution unit's opcode/address interface; each instruction takes five cycles, with no overlap between instructions.

## Interface
Parameters:
- PC_WIDTH, 8, instruction address width (1..8).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk.
- start  in  1  leave IDLE and begin fetching at pc=0.
- instr_addr  out  PC_WIDTH  instruction memory address.
- instr_rd_en  out  1  instruction memory read strobe.
- instr_data  in  16  instruction word, valid the cycle after instr_rd_en.
- opcode  out  4  opcode to the execution unit.
- opAAdr  out  3  operand A register address.
- opBAder  out  3  operand B register address.
- dest_reg  out  3  destination register address.
- data_mem_addr  out  8  data memory address for load/store.
- commit  out  1  write qualifier, high exactly one cycle per non-jump, non-halt instruction.
- halted  out  1  HALT executed.
- pc_out  out  PC_WIDTH  current program counter.

## Operation
Instruction format:
- Bits [15:12] are the opcode.
- ALU form: [11:9] dest, [8:6] opA, [5:3] opB, [2:0] ignored.
- LOAD (4'b0100): dest=[11:9], data_mem_addr=[7:0], opA/opB=0.
- STORE (4'b0101): opAAdr=[11:9], data_mem_addr=[7:0], dest=0, opB=0.
- JMP (4'b1110): target=[PC_WIDTH-1:0]; all register fields 0.
- HALT (4'b1111): all fields 0.
- Every other opcode is an ALU operation and is passed through unchanged.

State machine (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED):
- IDLE: wait for start; start=1 -> FETCH.
- FETCH: instr_rd_en=1, instr_addr=pc -> DECODE.
- DECODE: ir <= instr_data -> EXEC.
- EXEC: decoded fields driven from ir; data_mem_addr valid -> MEM.
- MEM: fields held; read data settles and the execution unit captures on the closing edge -> WB.
- WB:
  - ALU/LOAD/STORE: commit=1, pc <= pc+1 -> FETCH.
  - JMP: commit=0, pc <= target -> FETCH.
  - HALT: commit=0, pc unchanged -> HALTED.
- HALTED: halted=1; remain until reset. start is ignored.

Decoded outputs are combinational from ir. They stay stable from EXEC through the following DECODE.

## Timing
- Reset values: state=IDLE, pc=0, ir=0, every output 0.
- Fetch-to-commit latency is 4 cycles (FETCH at t, commit at t+4); next FETCH at t+5.
- Instruction memory has a 1-cycle synchronous read. Data memory has a 1-cycle synchronous read: address in EXEC, data in MEM.
- pc increments modulo 2^PC_WIDTH; max wraps to 0.
- start outside IDLE has no effect.
- Reset during any state: IDLE on the next edge. commit is suppressed that cycle and any in-flight instruction is abandoned.
- Reset and start high together: reset wins.
- JMP to its own address loops forever with no commit.

## Structure
- cu_pkg holds:
  - OP_LOAD=4'b0100, OP_STORE=4'b0101, OP_JMP=4'b1110, OP_HALT=4'b1111.
  - state_t enum.
  - field bit-position constants.
- Sub-module `cu_decoder`: combinational ir -> fields/data_mem_addr mapping. The FSM and pc stay in control_unit.

## Test plan
- Reset then start; memory[0]=16'h0A50 (opcode 0, dest 5, opA 1, opB 2) -> EXEC shows opcode=0, dest_reg=5, opAAdr=1, opBAder=2; commit high in cycle 4 after FETCH; pc_out=1.
- LOAD 16'h4612 -> dest_reg=3, data_mem_addr=8'h12 from EXEC through MEM; commit=1 in WB.
- STORE 16'h5A34 -> opAAdr=5, dest_reg=0, data_mem_addr=8'h34; commit=1 in WB.
- JMP 16'hE005 at pc=2 -> no commit; next instr_addr=5.
- HALT at pc=3 -> halted=1 permanently, instr_rd_en=0, start pulses ignored; reset clears halted and pc.
- PC_WIDTH=2, four ALU words -> instr_addr sequence 0,1,2,3,0. Reset asserted in MEM -> commit never rises; state IDLE next cycle.
